// File: rtl/bool_func_engine.sv
// Programmable multi-output truth-table evaluator with single-shot and sweep modes.
// Optional BOOL_PARITY_EN adds out_par and a per-sweep XOR checksum (sweep_xor).
module bool_func_engine #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 3,
    localparam int TT_W  = 1 << N_IN,
    localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    parameter logic [N_OUT*TT_W-1:0] TT_INIT = {8'h28, 8'h8B, 8'hCA}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [TT_W-1:0]  cfg_tt,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_vec,
    output logic [N_IN-1:0]  out_idx,
`ifdef BOOL_PARITY_EN
    output logic             out_par,
    output logic [N_OUT-1:0] sweep_xor,
`endif
    output logic             out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [N_IN-1:0]  r_cnt;
    logic [TT_W-1:0]  r_tt [N_OUT];

    logic             w_ld;
    logic             w_acc;
    logic             w_sweep_ld;
    logic             w_load;
    logic             w_xfer;
    logic             w_cfg_ok;
    logic [N_IN-1:0]  w_idx;
    logic [N_OUT-1:0] w_res;

    assign w_ld       = ~out_valid | out_ready;
    assign in_ready   = (r_state == S_IDLE) & ~start & w_ld;
    assign w_acc      = in_valid & in_ready;
    assign w_sweep_ld = (r_state == S_SWEEP) & w_ld;
    assign w_load     = w_acc | w_sweep_ld;
    assign w_xfer     = out_valid & out_ready;
    assign w_idx      = (r_state == S_SWEEP) ? r_cnt : in_vec;
    assign w_cfg_ok   = cfg_we & (r_state == S_IDLE)
                      & (32'(cfg_sel) < N_OUT);
    assign busy       = (r_state != S_IDLE);

    // Lookup reads the current table, so a same-cycle write is seen next cycle
    always_comb begin
        w_res = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_res[k] = r_tt[k][w_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_SWEEP;
            S_SWEEP: if (w_ld && (&r_cnt)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_xfer) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_OUT; k++) begin
                r_tt[k] <= TT_INIT[k*TT_W +: TT_W];
            end
            cfg_err <= 1'b0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (w_cfg_ok && (cfg_sel == SEL_W'(k))) begin
                    r_tt[k] <= cfg_tt;
                end
            end
            cfg_err <= cfg_we & ~w_cfg_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (w_sweep_ld) begin
                r_cnt <= r_cnt + N_IN'(1);
            end
            if (w_load) begin
                out_valid <= 1'b1;
                out_vec   <= w_res;
                out_idx   <= w_idx;
                out_last  <= w_sweep_ld & (&r_cnt);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            done <= (r_state == S_DRAIN) & w_xfer;
        end
    end

`ifdef BOOL_PARITY_EN
    logic [N_OUT-1:0] r_acc;

    // Accumulator restarts on index 0 so each sweep checksums only its own beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            out_par   <= 1'b0;
            sweep_xor <= '0;
        end else begin
            if (w_load) begin
                out_par <= ^w_res;
            end
            if (w_sweep_ld) begin
                r_acc <= (r_cnt == '0) ? w_res : (r_acc ^ w_res);
            end
            if ((r_state == S_DRAIN) && w_xfer) begin
                sweep_xor <= r_acc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bool_func_engine.sv
// Directed testbench for bool_func_engine; expected values hand-derived
// from the default tables f0=8'hCA, f1=8'h8B, f2=8'h28 with out_vec={f2,f1,f0}.
module tb_bool_func_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_tt;
    logic       cfg_err;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_vec;
    logic       start;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_vec;
    logic [2:0] out_idx;
    logic       out_last;
`ifdef BOOL_PARITY_EN
    logic       out_par;
    logic [2:0] sweep_xor;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Default-table sweep beats, index 0..7
    logic [2:0] EXP [8] = '{3'b010, 3'b011, 3'b000, 3'b111,
                            3'b000, 3'b100, 3'b001, 3'b011};

    always #5 clk = ~clk;

    bool_func_engine dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_tt    (cfg_tt),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_idx   (out_idx),
`ifdef BOOL_PARITY_EN
        .out_par   (out_par),
        .sweep_xor (sweep_xor),
`endif
        .out_last  (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic eval(input logic [2:0] v, input logic [2:0] exp);
        in_valid = 1'b1;
        in_vec   = v;
        tick();
        in_valid = 1'b0;
        chk("eval_valid", out_valid, 1'b1);
        chk("eval_vec", out_vec, exp);
        chk("eval_idx", out_idx, v);
        chk("eval_last", out_last, 1'b0);
    endtask

    task automatic run_sweep(input int stall_at);
        int  b    = 0;
        int  cyc  = 0;
        bit  seen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sweep_busy", busy, 1'b1);
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (out_valid) begin
                chk("beat_idx", out_idx, b[2:0]);
                chk("beat_vec", out_vec, EXP[b[2:0]]);
                chk("beat_last", out_last, (b == 7));
`ifdef BOOL_PARITY_EN
                chk("beat_par", out_par, ^EXP[b[2:0]]);
`endif
                if (b == stall_at) begin
                    out_ready = 1'b0;
                    repeat (3) begin
                        tick();
                        chk("hold_valid", out_valid, 1'b1);
                        chk("hold_idx", out_idx, b[2:0]);
                        chk("hold_vec", out_vec, EXP[b[2:0]]);
                    end
                    out_ready = 1'b1;
                end
                b++;
            end
            if (done) begin
                seen = 1'b1;
                chk("done_beats", b, 8);
                chk("done_busy", busy, 1'b0);
                chk("done_valid", out_valid, 1'b0);
`ifdef BOOL_PARITY_EN
                chk("sweep_xor", sweep_xor, 3'b000);
`endif
            end
        end
        chk("done_seen", seen, 1'b1);
        tick();
        chk("done_pulse", done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_sel   = 2'd0;
        cfg_tt    = 8'h00;
        in_valid  = 1'b0;
        in_vec    = 3'd0;
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_vec", out_vec, 3'b000);
        chk("rst_idx", out_idx, 3'd0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
`ifdef BOOL_PARITY_EN
        chk("rst_par", out_par, 1'b0);
        chk("rst_sxor", sweep_xor, 3'b000);
`endif
        rst = 1'b0;
        tick();
        chk("idle_ready", in_ready, 1'b1);
        start = 1'b1;
        #1;
        chk("start_blocks_ready", in_ready, 1'b0);
        start = 1'b0;
        #1;

        // Single evaluations on default tables
        eval(3'b110, 3'b001);
        eval(3'b101, 3'b100);

        // Write f0 := 8'h80 with a same-cycle evaluation seeing the old table
        cfg_we   = 1'b1;
        cfg_sel  = 2'd0;
        cfg_tt   = 8'h80;
        in_valid = 1'b1;
        in_vec   = 3'b110;
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        chk("same_cyc_vec", out_vec, 3'b001);
        chk("wr_ok_err", cfg_err, 1'b0);
        eval(3'b111, 3'b011);
        eval(3'b110, 3'b000);

        // Out-of-range select is rejected
        cfg_we  = 1'b1;
        cfg_sel = 2'd3;
        cfg_tt  = 8'hFF;
        tick();
        cfg_we  = 1'b0;
        chk("sel3_err", cfg_err, 1'b1);
        tick();
        chk("sel3_err_pulse", cfg_err, 1'b0);

        // Restore f0 to its reset value
        cfg_we  = 1'b1;
        cfg_sel = 2'd0;
        cfg_tt  = 8'hCA;
        tick();
        cfg_we  = 1'b0;
        eval(3'b110, 3'b001);

        // Full sweep, then sweep with a 3-cycle stall on index 3
        run_sweep(-1);
        run_sweep(3);

        // Write during a sweep is rejected and leaves f0 intact
        start = 1'b1;
        tick();
        start   = 1'b0;
        cfg_we  = 1'b1;
        cfg_sel = 2'd0;
        cfg_tt  = 8'h00;
        tick();
        cfg_we  = 1'b0;
        chk("busy_err", cfg_err, 1'b1);
        tick();
        chk("busy_err_pulse", cfg_err, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (done) found = 1'b1;
        end
        chk("busy_sweep_done", found, 1'b1);
        tick();
        eval(3'b110, 3'b001);

        // Reset at index 5 aborts the sweep
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (out_valid && out_idx == 3'd5) found = 1'b1;
        end
        chk("idx5_seen", found, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_valid", out_valid, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        run_sweep(-1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
